// File: rtl/word_mux_sequencer_if.sv
// ---------------------------------------------------------------------------
// word_mux_sequencer_if
//   Request side and output stream of word_mux_sequencer, grouped into one bundle.
//
//   Request side (master drives, slave consumes):
//     inData    NUM_CH packed words; word k = inData[k*DATA_W +: DATA_W]
//     inSel     word index used in direct mode
//     inMode    0 = direct, 1 = sequence
//     inValid   request valid
//     outAccept request accepted when inValid && outAccept
//   Output stream (slave drives, master consumes):
//     outData   registered output word
//     outValid  outData valid
//     inReady   downstream ready; a beat moves when outValid && inReady
//     outLast   final beat of a request
//     outIdx    index of the word on outData
//     outBusy   a sequence still has words to load
// ---------------------------------------------------------------------------
interface word_mux_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH*DATA_W-1:0] inData;
  logic [SEL_W-1:0]         inSel;
  logic                     inMode;
  logic                     inValid;
  logic                     outAccept;
  logic [DATA_W-1:0]        outData;
  logic                     outValid;
  logic                     inReady;
  logic                     outLast;
  logic [SEL_W-1:0]         outIdx;
  logic                     outBusy;

  // Requester / downstream consumer side.
  modport master (
    output inData, inSel, inMode, inValid, inReady,
    input  outAccept, outData, outValid, outLast, outIdx, outBusy
  );

  // Sequencer side.
  modport slave (
    input  inData, inSel, inMode, inValid, inReady,
    output outAccept, outData, outValid, outLast, outIdx, outBusy
  );
endinterface

// File: rtl/word_mux_sequencer.sv
// ---------------------------------------------------------------------------
// word_mux_sequencer
//   Registered word multiplexer with a valid/ready output stream.
//   Direct mode returns one selected word. Sequence mode snapshots all
//   NUM_CH words and then streams them out in index order, one word per
//   handshake.
//
//   Ports:
//     inClk     clock, all state on the rising edge
//     inResetN  asynchronous active-low reset
//     bus       word_mux_sequencer_if.slave (request side + output stream)
// ---------------------------------------------------------------------------
module word_mux_sequencer #(
  parameter int DATA_W = 4,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  inClk,
  input  logic                  inResetN,
  word_mux_sequencer_if.slave   bus
);

  typedef enum logic {IDLE, SEQ} state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

  state_t                   state_reg, state_next;
  logic [NUM_CH*DATA_W-1:0] snap_reg, snap_next;
  logic [DATA_W-1:0]        data_reg, data_next;
  logic [SEL_W-1:0]         idx_reg, idx_next;
  logic                     last_reg, last_next;
  logic                     valid_reg, valid_next;

  logic [DATA_W-1:0] in_words   [NUM_CH];
  logic [DATA_W-1:0] snap_words [NUM_CH];
  logic [DATA_W-1:0] direct_word;
  logic [SEL_W-1:0]  idx_inc;
  logic              sel_in_range;
  logic              adv;
  logic              accept_ok;
  logic              accept;

  // Unpack the live input words and the snapshot into word arrays.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_words
      assign in_words[gi]   = bus.inData[gi*DATA_W +: DATA_W];
      assign snap_words[gi] = snap_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // The output register may only load when it is empty or being drained.
  assign adv = !valid_reg || bus.inReady;

  // Gated by reset so no request can be accepted while reset is held,
  // even though the IDLE/empty state would otherwise allow it.
  assign accept_ok = inResetN && (state_reg == IDLE) && adv;
  assign accept    = bus.inValid && accept_ok;

  // Out-of-range selects (only possible when NUM_CH is not a power of 2)
  // return a zero word rather than an undefined lane.
  assign sel_in_range = (32'(bus.inSel) < NUM_CH);
  assign direct_word  = sel_in_range ? in_words[bus.inSel] : '0;

  // In SEQ the index never reaches LAST_IDX, so the increment cannot wrap.
  assign idx_inc = idx_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    snap_next  = snap_reg;
    data_next  = data_reg;
    idx_next   = idx_reg;
    last_next  = last_reg;
    valid_next = valid_reg;

    if (adv) begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            valid_next = 1'b1;
            if (bus.inMode) begin
              snap_next = bus.inData;
              data_next = in_words[0];
              idx_next  = '0;
              last_next = (NUM_CH == 1);
              if (NUM_CH > 1) begin
                state_next = SEQ;
              end
            end else begin
              data_next = direct_word;
              idx_next  = bus.inSel;
              last_next = 1'b1;
            end
          end else begin
            // Drained with nothing new: drop valid, keep data/index visible.
            valid_next = 1'b0;
            last_next  = 1'b0;
          end
        end
        SEQ: begin
          // Valid is always high here, so adv means the current beat moved.
          idx_next  = idx_inc;
          data_next = snap_words[idx_inc];
          last_next = (idx_inc == LAST_IDX);
          // Leave SEQ as the final word loads, so a new request can be
          // accepted on the edge that transfers it.
          if (idx_inc == LAST_IDX) begin
            state_next = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      state_reg <= IDLE;
      snap_reg  <= '0;
      data_reg  <= '0;
      idx_reg   <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      snap_reg  <= snap_next;
      data_reg  <= data_next;
      idx_reg   <= idx_next;
      last_reg  <= last_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.outAccept = accept_ok;
  assign bus.outData   = data_reg;
  assign bus.outValid  = valid_reg;
  assign bus.outLast   = last_reg;
  assign bus.outIdx    = idx_reg;
  assign bus.outBusy   = (state_reg == SEQ);

endmodule

// File: doc/word_mux_sequencer.md
Name: word_mux_sequencer

Overview:
Parametrised, registered word multiplexer with a valid/ready output stream.
- Direct mode: selects one of NUM_CH packed words by index.
- Sequence mode: snapshots all NUM_CH words and emits them in index order, one beat per handshake.
- Replaces the flat combinational bit-lane muxes in the Zigbee TX datapath, e.g. serialising chip/symbol nibbles toward the modulator with backpressure.

Parameters:
DATA_W, 4, width of one word
NUM_CH, 8, number of packed input words (>=1)
SEL_W, $clog2(NUM_CH) (min 1), width of select/index

Ports:
inClk  input  1  clock, all state on rising edge
inResetN  input  1  reset, asynchronous, active-low
inData  input  NUM_CH*DATA_W  packed words; word k = inData[k*DATA_W +: DATA_W]
inSel  input  SEL_W  word index used in direct mode
inMode  input  1  0 = direct, 1 = sequence
inValid  input  1  request valid; inData/inSel/inMode qualified by it
outAccept  output  1  request accepted this cycle when inValid && outAccept
outData  output  DATA_W  registered output word
outValid  output  1  outData valid
inReady  input  1  downstream ready; beat transfers when outValid && inReady
outLast  output  1  final beat of a request
outIdx  output  SEL_W  index of the word on outData
outBusy  output  1  high while a sequence has words still to load

Behaviour:
- Reset (inResetN=0, asynchronous, no clock needed):
  - outData=0, outValid=0, outLast=0, outIdx=0, outBusy=0.
  - Snapshot register = 0; state = IDLE.
  - outAccept is forced 0 while reset is asserted.
- adv = !outValid || inReady. The output register may load only when adv = 1.
- Stall: while outValid && !inReady, outData, outIdx and outLast hold; no state change.
- States: IDLE, SEQ. outBusy = (state == SEQ). outAccept = (state == IDLE) && adv.
- IDLE, accept (inValid && outAccept); inSel and inMode are sampled only here:
  - Direct mode (inMode=0), inSel < NUM_CH: outData <= word[inSel], outIdx <= inSel, outLast <= 1, outValid <= 1.
  - Direct mode, inSel >= NUM_CH (NUM_CH not a power of 2): outData <= 0, outIdx <= inSel, outLast <= 1, outValid <= 1.
  - Sequence mode (inMode=1): snapshot <= inData, outData <= word0, outIdx <= 0, outValid <= 1, outLast <= (NUM_CH==1). Go to SEQ unless NUM_CH==1.
- IDLE, no accept, adv=1: outValid <= 0, outLast <= 0. outData and outIdx hold.
- SEQ, on transfer (inReady=1; outValid is always 1 in SEQ):
  - outIdx <= outIdx+1; outData <= snapshot word[outIdx+1].
  - outLast <= (outIdx+1 == NUM_CH-1).
  - If the loaded word is the last one: state <= IDLE, so outBusy drops while the last word is still presented.
- SEQ: changes on inData are ignored (snapshot only); no index wrap-around beyond NUM_CH-1.
- Latency: accept-to-outValid is 1 cycle.
- Throughput: a sequence takes exactly NUM_CH beats. A new request accepted on the cycle the last beat transfers follows with no bubble.
- Simultaneous last-beat transfer and new inValid: both occur in the same edge; the new request loads the register.
- Reset mid-sequence: aborts immediately, snapshot discarded, no partial resume after release.

Test Plan:
1. Hold inResetN=0 with inValid=1, inReady=1, clock running -> all outputs 0, outAccept=0. Release -> outAccept=1 on the first cycle after release.
2. DATA_W=4, NUM_CH=8, inData=32'h76543210, inMode=0, inSel=5, inReady=1, one-cycle pulse -> next cycle outData=4'h5, outIdx=5, outLast=1, outValid=1. The cycle after, outValid=0 and outData holds 5.
3. inData=32'hFEDCBA98, inMode=1, inReady=1 -> consecutive beats outData=8,9,A,B,C,D,E,F with outIdx=0..7. outLast=1 only with F. outBusy=1 during words 0..6 and 0 during word 7.
4. Same sequence, inReady=0 for 3 cycles while outIdx=3, and inData changed to 0 during the stall -> B held 3 extra cycles, then C..F emitted unchanged (snapshot honoured). outAccept=0 throughout.
5. Two sequence requests back-to-back (inValid held, second inData=32'h01234567) -> 16 contiguous beats 8..F then 7..0, outLast on beats 8 and 16, no idle cycle between frames.
6. Assert inResetN=0 between clock edges while outIdx=4 -> outputs go to 0 before the next edge. After release: state IDLE, outBusy=0, remaining words 5..7 never emitted.
